// File: rtl/id_stage_hazard_pipe.sv
// id_stage_hazard_pipe: MIPS decode stage with hazard detection and ID/EX register (define ID_BYPASS_EN for write-back to ID bypass)
module id_stage_hazard_pipe #(
  parameter int DATA_W = 32,
  parameter int PC_W = 10,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PC_W-1:0]       if_id_pc_plus4,
  input  logic [31:0]           if_id_instr,
  input  logic                  flush,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_write_addr,
  input  logic [DATA_W-1:0]     wb_write_data,
  output logic                  stall,
  output logic                  branch_taken,
  output logic [PC_W-1:0]       branch_address,
  output logic                  jump,
  output logic [PC_W-1:0]       jump_address,
  output logic [DATA_W-1:0]     ex_reg1,
  output logic [DATA_W-1:0]     ex_reg2,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic [1:0]            ex_alu_op,
  output logic                  ex_mem_to_reg,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_alu_src,
  output logic                  ex_reg_write
);
  logic [DATA_W-1:0] rf [2**REG_ADDR_W];
  logic [5:0] op;
  logic [REG_ADDR_W-1:0] rs, rt, rd, mem_dest;
  logic [DATA_W-1:0] rd1, rd2, imm;
  logic mem_mem_read, r_type, lw, sw, addi, beq, bne, branch, uses_rt;
  logic hit_ex, hit_mem, hazard_wb, bubble;
  assign op = if_id_instr[31:26];
  assign rs = REG_ADDR_W'(if_id_instr[25:21]);
  assign rt = REG_ADDR_W'(if_id_instr[20:16]);
  assign rd = REG_ADDR_W'(if_id_instr[15:11]);
  assign imm = DATA_W'($signed(if_id_instr[15:0]));
  assign r_type = op == 6'h00;
  assign lw = op == 6'h23;
  assign sw = op == 6'h2B;
  assign addi = op == 6'h08;
  assign beq = op == 6'h04;
  assign bne = op == 6'h05;
  assign branch = beq || bne;
  assign uses_rt = r_type || sw || branch;
  assign hit_ex = ex_dest != '0 && (ex_dest == rs || uses_rt && ex_dest == rt);
  assign hit_mem = mem_dest != '0 && (mem_dest == rs || uses_rt && mem_dest == rt);
`ifdef ID_BYPASS_EN
  assign rd1 = rs == '0 ? '0 : wb_reg_write && wb_write_addr == rs ? wb_write_data : rf[rs];
  assign rd2 = rt == '0 ? '0 : wb_reg_write && wb_write_addr == rt ? wb_write_data : rf[rt];
  assign hazard_wb = 1'b0;
`else
  logic hit_wb;
  assign hit_wb = wb_write_addr != '0 && (wb_write_addr == rs || uses_rt && wb_write_addr == rt);
  assign rd1 = rs == '0 ? '0 : rf[rs];
  assign rd2 = rt == '0 ? '0 : rf[rt];
  assign hazard_wb = wb_reg_write && hit_wb;
`endif
  assign stall = !flush && (ex_mem_read && hit_ex || branch && (ex_reg_write && hit_ex || mem_mem_read && hit_mem) || hazard_wb);
  assign bubble = stall || flush;
  assign branch_taken = branch && !bubble && (beq ? rd1 == rd2 : rd1 != rd2);
  assign branch_address = if_id_pc_plus4 + {imm[PC_W-3:0], 2'b00};
  assign jump = op == 6'h02 && !bubble;
  assign jump_address = {if_id_instr[PC_W-3:0], 2'b00};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < 2**REG_ADDR_W; i++) rf[i] <= '0;
      {mem_dest, mem_mem_read} <= '0;
      {ex_reg1, ex_reg2, ex_imm, ex_rs, ex_rt, ex_dest, ex_alu_op} <= '0;
      {ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_write} <= '0;
    end else begin
      if (wb_reg_write && wb_write_addr != '0) rf[wb_write_addr] <= wb_write_data;
      mem_dest <= ex_dest;
      mem_mem_read <= ex_mem_read;
      {ex_reg1, ex_reg2, ex_imm, ex_rs, ex_rt, ex_dest, ex_alu_op} <= bubble ? '0 :
        {rd1, rd2, imm, rs, rt, r_type ? rd : rt, r_type, branch};
      {ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_write} <= bubble ? '0 :
        {lw, lw, sw, lw || sw || addi, r_type || lw || addi};
    end
endmodule

// File: tb/tb_id_stage_hazard_pipe.sv
// tb_id_stage_hazard_pipe: directed and randomized checks of id_stage_hazard_pipe against a behavioural model
module tb_id_stage_hazard_pipe;
  localparam logic [31:0] NOP = 32'hFC00_0000;
`ifdef ID_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, flush, wb_reg_write;
  logic [9:0] if_id_pc_plus4, branch_address, jump_address;
  logic [31:0] if_id_instr, wb_write_data, ex_reg1, ex_reg2, ex_imm;
  logic [4:0] wb_write_addr, ex_rs, ex_rt, ex_dest;
  logic [1:0] ex_alu_op;
  logic stall, branch_taken, jump, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_write;
  always #5 clk = ~clk;
  id_stage_hazard_pipe dut (
    .clk(clk), .reset(reset), .if_id_pc_plus4(if_id_pc_plus4), .if_id_instr(if_id_instr),
    .flush(flush), .wb_reg_write(wb_reg_write), .wb_write_addr(wb_write_addr),
    .wb_write_data(wb_write_data), .stall(stall), .branch_taken(branch_taken),
    .branch_address(branch_address), .jump(jump), .jump_address(jump_address),
    .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_dest(ex_dest), .ex_alu_op(ex_alu_op), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
    .ex_reg_write(ex_reg_write)
  );
  typedef struct packed {
    logic [31:0] reg1, reg2, imm;
    logic [4:0] rs, rt, dest;
    logic [1:0] alu_op;
    logic mem_to_reg, mem_read, mem_write, alu_src, reg_write;
  } ex_t;
  ex_t ex_m, ex_n;
  logic [31:0] regs [32];
  logic [4:0] m_dest;
  logic m_mr, e_stall, e_taken, e_jump;
  logic [9:0] e_baddr, e_jaddr;
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] ri(input logic [4:0] rs, rt, rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction
  function automatic logic [31:0] ii(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic dep(input logic [4:0] x, rs, rt, input logic ut);
    return x != 0 && (x == rs || ut && x == rt);
  endfunction
  function automatic logic [31:0] rdreg(input logic [4:0] a);
    if (a == 0) return 0;
    if (BYP && wb_reg_write && wb_write_addr == a) return wb_write_data;
    return regs[a];
  endfunction
  task automatic clear_model();
    ex_m = '0;
    m_dest = 0;
    m_mr = 0;
    for (int i = 0; i < 32; i++) regs[i] = 0;
  endtask
  task automatic model_comb();
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    logic isr, lw, sw, ad, bq, br, ut, haz;
    logic [31:0] r1, r2;
    int off;
    op = if_id_instr[31:26]; rs = if_id_instr[25:21]; rt = if_id_instr[20:16]; rd = if_id_instr[15:11];
    isr = op == 0; lw = op == 6'h23; sw = op == 6'h2B; ad = op == 6'h08; bq = op == 6'h04;
    br = bq || op == 6'h05;
    ut = isr || sw || br;
    haz = ex_m.mem_read && dep(ex_m.dest, rs, rt, ut)
       || br && ex_m.reg_write && dep(ex_m.dest, rs, rt, ut)
       || br && m_mr && dep(m_dest, rs, rt, ut)
       || !BYP && wb_reg_write && dep(wb_write_addr, rs, rt, ut);
    e_stall = !flush && haz;
    r1 = rdreg(rs);
    r2 = rdreg(rt);
    e_taken = br && !e_stall && !flush && (bq ? r1 == r2 : r1 != r2);
    off = int'($signed(if_id_instr[15:0])) * 4;
    e_baddr = 10'((int'(if_id_pc_plus4) + off) & 1023);
    e_jaddr = 10'(int'(if_id_instr & 32'hFF) * 4);
    e_jump = op == 6'h02 && !e_stall && !flush;
    ex_n = '0;
    if (!(e_stall || flush)) begin
      ex_n.reg1 = r1; ex_n.reg2 = r2;
      ex_n.imm = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
      ex_n.rs = rs; ex_n.rt = rt; ex_n.dest = isr ? rd : rt;
      ex_n.alu_op = isr ? 2'b10 : br ? 2'b01 : 2'b00;
      ex_n.mem_to_reg = lw; ex_n.mem_read = lw; ex_n.mem_write = sw;
      ex_n.alu_src = lw || sw || ad; ex_n.reg_write = isr || lw || ad;
    end
  endtask
  task automatic check_ex();
    chk("ex_reg1", ex_reg1, ex_m.reg1);
    chk("ex_reg2", ex_reg2, ex_m.reg2);
    chk("ex_imm", ex_imm, ex_m.imm);
    chk("ex_ctl", {ex_rs, ex_rt, ex_dest, ex_alu_op, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_write},
        {ex_m.rs, ex_m.rt, ex_m.dest, ex_m.alu_op, ex_m.mem_to_reg, ex_m.mem_read, ex_m.mem_write, ex_m.alu_src, ex_m.reg_write});
  endtask
  task automatic drive(input logic [31:0] ins, input logic [9:0] pc, input logic fl, input logic w,
                       input logic [4:0] wa, input logic [31:0] wd);
    if_id_instr = ins; if_id_pc_plus4 = pc; flush = fl;
    wb_reg_write = w; wb_write_addr = wa; wb_write_data = wd;
    #1;
    model_comb();
    chk("stall", stall, e_stall);
    chk("branch_taken", branch_taken, e_taken);
    chk("branch_address", branch_address, e_baddr);
    chk("jump", jump, e_jump);
    chk("jump_address", jump_address, e_jaddr);
  endtask
  task automatic tick();
    @(posedge clk);
    if (reset) clear_model();
    else begin
      m_dest = ex_m.dest;
      m_mr = ex_m.mem_read;
      if (wb_reg_write && wb_write_addr != 0) regs[wb_write_addr] = wb_write_data;
      ex_m = ex_n;
    end
    @(negedge clk);
    check_ex();
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    drive(NOP, 10'h0, 1'b0, 1'b1, a, d);
    tick();
  endtask
  initial begin
    logic [31:0] jins, rins;
    if_id_instr = NOP; if_id_pc_plus4 = 0; flush = 0;
    wb_reg_write = 0; wb_write_addr = 0; wb_write_data = 0;
    clear_model();
    @(negedge clk);
    check_ex();
    chk("rst_stall", stall, 1'b0);
    reset = 1'b0;
    wr(5'd1, 32'h100); wr(5'd4, 32'h5); wr(5'd5, 32'h77); wr(5'd2, 32'h77);
    // load-use: one stall, bubble, then the dependent add issues
    drive(ii(6'h23, 5'd1, 5'd2, 16'h0), 10'h10, 0, 0, 0, 0); tick();
    drive(ri(5'd2, 5'd4, 5'd3), 10'h14, 0, 0, 0, 0);
    chk("lu_stall", stall, 1'b1);
    tick();
    chk("lu_bubble", {ex_mem_read, ex_reg_write, ex_dest}, 7'd0);
    drive(ri(5'd2, 5'd4, 5'd3), 10'h14, 0, 0, 0, 0);
    chk("lu_release", stall, 1'b0);
    tick();
    chk("add_issue", {ex_rs, ex_rt, ex_dest}, {5'd2, 5'd4, 5'd3});
    // lw then dependent beq: two stall cycles, then taken
    drive(ii(6'h23, 5'd1, 5'd2, 16'h0), 10'h1C, 0, 0, 0, 0); tick();
    drive(ii(6'h04, 5'd2, 5'd5, 16'h4), 10'h20, 0, 0, 0, 0);
    chk("bl_stall1", stall, 1'b1);
    tick();
    drive(ii(6'h04, 5'd2, 5'd5, 16'h4), 10'h20, 0, 0, 0, 0);
    chk("bl_stall2", stall, 1'b1);
    tick();
    drive(ii(6'h04, 5'd2, 5'd5, 16'h4), 10'h20, 0, 0, 0, 0);
    chk("bl_go", stall, 1'b0);
    chk("beq_taken", branch_taken, 1'b1);
    chk("beq_target", branch_address, 10'h030);
    tick();
    drive(ii(6'h05, 5'd1, 5'd1, 16'h4), 10'h40, 0, 0, 0, 0);
    chk("bne_same", branch_taken, 1'b0);
    tick();
    drive(ii(6'h04, 5'd0, 5'd0, 16'hFFFF), 10'h004, 0, 0, 0, 0);
    chk("beq_back_taken", branch_taken, 1'b1);
    chk("beq_back_addr", branch_address, 10'h000);
    tick();
    drive(ii(6'h04, 5'd0, 5'd0, 16'hFFFF), 10'h000, 0, 0, 0, 0);
    chk("beq_wrap_addr", branch_address, 10'h3FC);
    tick();
    // flush beats a pending hazard and kills the jump
    jins = {6'h02, 5'd2, 5'd9, 16'h0015};
    drive(ii(6'h23, 5'd1, 5'd2, 16'h0), 10'h50, 0, 0, 0, 0); tick();
    drive(jins, 10'h54, 0, 0, 0, 0);
    chk("j_hazard_stall", stall, 1'b1);
    chk("j_hazard_jump", jump, 1'b0);
    drive(jins, 10'h54, 1, 0, 0, 0);
    chk("flush_stall", stall, 1'b0);
    chk("flush_jump", jump, 1'b0);
    tick();
    chk("flush_bubble", {ex_rs, ex_dest, ex_reg_write}, 11'd0);
    drive(jins, 10'h54, 0, 0, 0, 0);
    chk("j_go", jump, 1'b1);
    chk("j_addr", jump_address, 10'h054);
    tick();
    // same-cycle write-back and read of $7
    drive(NOP, 10'h0, 0, 0, 0, 0); tick();
    rins = ri(5'd7, 5'd0, 5'd8);
    drive(rins, 10'h60, 0, 1, 5'd7, 32'hDEAD);
    chk("wb_stall", stall, !BYP);
    tick();
    chk("wb_first", ex_reg1, BYP ? 32'hDEAD : 32'h0);
    drive(rins, 10'h60, 0, 0, 0, 0);
    chk("wb_nostall", stall, 1'b0);
    tick();
    chk("wb_value", ex_reg1, 32'hDEAD);
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      case ($urandom_range(0, 7))
        0: op = 6'h00; 1: op = 6'h23; 2: op = 6'h2B; 3: op = 6'h08;
        4: op = 6'h04; 5: op = 6'h05; 6: op = 6'h02; default: op = 6'($urandom);
      endcase
      drive({op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 11'($urandom)},
            10'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
            5'($urandom_range(0, 7)), 32'($urandom_range(0, 3)));
      tick();
    end
    // asynchronous reset mid-run clears pipeline and register file
    drive(ii(6'h23, 5'd1, 5'd2, 16'h0), 10'h70, 0, 0, 0, 0); tick();
    reset = 1'b1;
    wb_reg_write = 0;
    #1;
    clear_model();
    check_ex();
    chk("rst_mid_stall", stall, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 1; i < 32; i += 3) begin
      drive(ri(5'(i), 5'(i + 1), 5'd0), 10'h0, 0, 0, 0, 0);
      tick();
      chk("rst_reg_read", {ex_reg1, ex_reg2}, 64'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
